// File: rtl/pipe_skid_reg.sv
// Two-slot pipeline register (MAIN + SKID) with registered ready, flush,
// zeroed idle slots and a saturating back-pressure counter.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_flag,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned INSTR_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [DATA_W-1:0]  data;
        logic               flag;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_in_entry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_in_entry = '{instr: in_instr, pc: in_pc, data: in_data, flag: in_flag};
    assign w_push     = in_valid && r_in_ready;
    assign w_pop      = r_out_valid && out_ready;

    // Next state; flush overrides any push/pop in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = S_FULL;
                    else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered so in_ready never depends on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_FULL);
            r_out_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    // Slot datapath; any slot that becomes empty is cleared to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) r_main <= w_in_entry;
                end
                S_ONE: begin
                    if (w_push && w_pop)   r_main <= w_in_entry;
                    else if (w_push)       r_skid <= w_in_entry;
                    else if (w_pop)        r_main <= '0;
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_main <= r_skid;
                        r_skid <= '0;
                    end
                end
                default: begin
                    r_main <= '0;
                    r_skid <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles where the head entry is held back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_state;
    assign out_instr = r_main.instr;
    assign out_pc    = r_main.pc;
    assign out_data  = r_main.data;
    assign out_flag  = r_main.flag;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the data payload lane.
REQ-002 SHALL have parameter PC_W, default 32, width of the PC field.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_instr  input  32  instruction word.
REQ-010 in_pc  input  PC_W  instruction PC.
REQ-011 in_data  input  DATA_W  payload, e.g. ALU result.
REQ-012 in_flag  input  1  side flag.
REQ-013 out_valid  output  1  entry presented downstream.
REQ-014 out_ready  input  1  downstream accepts this cycle.
REQ-015 out_instr, out_pc, out_data, out_flag  output  32/PC_W/DATA_W/1  head-entry fields.
REQ-016 occupancy  output  2  number of held entries, 0..2.
REQ-017 stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-018 Push SHALL be defined as in_valid && in_ready; pop SHALL be defined as out_valid && out_ready.
REQ-019 The stage SHALL have two storage slots, MAIN and SKID, and states EMPTY, ONE and FULL; occupancy SHALL be 0, 1 or 2 respectively.
REQ-020 in_ready SHALL be 1 exactly when state != FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 exactly when state != EMPTY; out_* SHALL be driven directly from MAIN.
REQ-022 EMPTY + push SHALL go to ONE with MAIN <= input.
REQ-023 EMPTY + no push SHALL hold.
REQ-024 ONE + push + pop SHALL stay ONE with MAIN <= input, sustaining 1 entry per cycle.
REQ-025 ONE + push + no pop SHALL go to FULL with SKID <= input and MAIN held.
REQ-026 ONE + pop + no push SHALL go to EMPTY with MAIN cleared to 0.
REQ-027 ONE + no push + no pop SHALL hold.
REQ-028 FULL + pop SHALL go to ONE with MAIN <= SKID and SKID cleared to 0.
REQ-029 FULL + no pop SHALL hold.
REQ-030 Push SHALL be impossible in FULL, since in_ready is 0.
REQ-031 Latency SHALL be one cycle: an entry pushed at edge N SHALL be visible on out_* after edge N when the stage was EMPTY, or was ONE with a pop at edge N.
REQ-032 Entries SHALL leave in push order; no entry SHALL be dropped or duplicated except by flush.
REQ-033 Any slot that is not valid SHALL hold all-zero fields, so out_instr is 0 (NOP) and out_pc, out_data and out_flag are 0 whenever out_valid is 0.
REQ-034 flush SHALL take priority over push and pop: on the next edge the state SHALL become EMPTY, both slots SHALL clear to 0, and an input pushed in that same cycle SHALL be discarded.
REQ-035 stall_cnt SHALL increment by 1 on every edge where out_valid && !out_ready, saturating at 2^CNT_W-1 with no wrap.
REQ-036 stall_cnt SHALL be unaffected by flush.
REQ-037 All field widths SHALL follow the parameters with no truncation or sign extension; in_pc and in_data SHALL pass through bit-exact.

Reset
REQ-038 While reset is high, the state SHALL be EMPTY, MAIN and SKID SHALL be all 0, and stall_cnt SHALL be 0.
REQ-039 While reset is high, the outputs SHALL be out_valid=0, in_ready=1, occupancy=0 and out_*=0.
REQ-040 Reset asserted mid-operation, including in FULL, SHALL discard all entries asynchronously, without waiting for a clock edge.
REQ-041 After reset deasserts, the first clk edge SHALL operate normally from EMPTY.

Verification
REQ-042 Streaming: out_ready=1; push instr 0x11111111, 0x22222222, 0x33333333 on consecutive cycles -> out_instr shows them on consecutive cycles one cycle later; occupancy stays 1; in_ready stays 1.
REQ-043 Back-pressure: out_ready=0; push A=0xAAAA0001, then B=0xBBBB0002 -> occupancy 2, in_ready=0, out_instr=A; raise out_ready -> out A, then out B, then out_valid=0 and out_instr=0; stall_cnt equals the number of stalled cycles.
REQ-044 Flush in FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_*=0, in_ready=1; the offered entry never appears; stall_cnt unchanged.
REQ-045 Async reset: raise reset between edges while FULL -> out_valid=0, occupancy=0 and stall_cnt=0 before the next edge.
REQ-046 Saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-047 Width: DATA_W=64, PC_W=30; push in_data=0xFFFF0000_12345678, in_pc=0x3FFFFFFC -> both appear unchanged on out_data and out_pc.
